// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Package : sha_pkg
// Purpose : Definitions shared by the SHA-256 message writer and the SHA-256
//           engine. Contents: the message-writer state encoding, the block
//           geometry constants and the padded block-count helper.
// Revision: 1.0  initial release
// ============================================================================
package sha_pkg;

  // A 512-bit block holds sixteen 32-bit words.
  localparam int          BLOCK_WORDS = 16;

  // The first padding word carries the mandatory '1' bit in its MSB.
  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PAD    = 3'd2,
    ST_ZERO   = 3'd3,
    ST_LEN_HI = 3'd4,
    ST_LEN_LO = 3'd5,
    ST_DONE   = 3'd6
  } sha_state_e;

  // Blocks required for a message of 'words' words. The padded message needs
  // the words themselves, one pad word and two length words, rounded up to a
  // whole block: ceil((words + 3) / 16) = (words + 18) >> 4.
  function automatic logic [7:0] sha_num_blocks(input logic [15:0] words);
    logic [15:0] total;
    total = words + 16'd18;
    return 8'(total >> 4);
  endfunction

endpackage : sha_pkg
`default_nettype wire

// File: rtl/sha_msg_writer.sv
`default_nettype none
// ============================================================================
// Module  : sha_msg_writer
// Purpose : Accepts a host message as a stream of 32-bit words and writes it
//           into word-addressed memory, followed by SHA-256 padding: a
//           0x80000000 word, zero fill and a 64-bit big-endian bit length,
//           so that the image occupies a whole number of 512-bit blocks.
// Ports   : clk, reset_n     - clock, asynchronous active-low reset
//           start, base_addr - begin a new message at word address base_addr
//           s_valid, s_data, s_last, s_ready - host word stream
//           mem_we, mem_addr, mem_write_data - one-word-per-cycle write port
//           num_blocks       - 512-bit blocks written (valid with done)
//           done             - one-cycle completion pulse
// Revision: 1.0  initial release
// ============================================================================
module sha_msg_writer
  import sha_pkg::*;
#(
  parameter int MAX_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [7:0]  num_blocks,
  output logic        done
);

  localparam logic [15:0] MAX_W = MAX_WORDS[15:0];

  sha_state_e  state;
  sha_state_e  next_state;

  logic [15:0] base;       // captured base address
  logic [15:0] ofs;        // word offset of the current write (n during LOAD)
  logic [15:0] msg_words;  // final message length n
  logic [7:0]  nb;         // padded block count
  logic [15:0] blk_end;    // 16*nb: offset one past the last padded word
  logic        load_last;  // accepted word ends the message

  assign blk_end   = 16'(nb) * 16'(BLOCK_WORDS);
  // In LOAD s_ready is 1, so s_valid alone means a word is accepted. Hitting
  // MAX_WORDS terminates the message exactly as s_last would.
  assign load_last = s_valid && (s_last || (ofs + 16'd1 == MAX_W));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_LOAD;
      ST_LOAD:   if (load_last) next_state = ST_PAD;
      // ZERO is skipped when the pad word lands directly before the length.
      ST_PAD:    next_state = (ofs + 16'd1 == blk_end - 16'd2) ? ST_LEN_HI : ST_ZERO;
      ST_ZERO:   if (ofs == blk_end - 16'd3) next_state = ST_LEN_HI;
      ST_LEN_HI: next_state = ST_LEN_LO;
      ST_LEN_LO: next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: write-port mux driven by the current state
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    done           = 1'b0;
    case (state)
      ST_LOAD: begin
        s_ready        = 1'b1;
        mem_we         = s_valid;
        mem_addr       = base + ofs;
        mem_write_data = s_data;
      end
      ST_PAD: begin
        mem_we         = 1'b1;
        mem_addr       = base + ofs;
        mem_write_data = PAD_WORD;
      end
      ST_ZERO, ST_LEN_HI: begin
        mem_we         = 1'b1;
        mem_addr       = base + ofs;
      end
      ST_LEN_LO: begin
        mem_we         = 1'b1;
        mem_addr       = base + ofs;
        mem_write_data = 32'({msg_words, 5'b0});  // bit length = n * 32
      end
      ST_DONE: begin
        done           = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base      <= 16'd0;
      ofs       <= 16'd0;
      msg_words <= 16'd0;
      nb        <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base      <= base_addr;
            ofs       <= 16'd0;
            msg_words <= 16'd0;
            nb        <= 8'd0;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            ofs <= ofs + 16'd1;
            if (load_last) begin
              msg_words <= ofs + 16'd1;
              nb        <= sha_num_blocks(ofs + 16'd1);
            end
          end
        end
        // After LOAD the offset simply walks through the padding words.
        ST_PAD, ST_ZERO, ST_LEN_HI: ofs <= ofs + 16'd1;
        default: ;
      endcase
    end
  end

  assign num_blocks = nb;

endmodule : sha_msg_writer
`default_nettype wire

// File: tb/tb_sha_msg_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha_msg_writer
// Purpose : Directed self-checking bench for sha_msg_writer. Host words are
//           1, 2, 3, ...; every write is logged and compared against
//           hand-derived expected images.
// Revision: 1.0  initial release
// ============================================================================
module tb_sha_msg_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [7:0]  num_blocks;
  logic        done;

  sha_msg_writer #(.MAX_WORDS(20)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .num_blocks     (num_blocks),
    .done           (done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int          done_cnt = 0;
  int          gap_we   = 0;
  logic [7:0]  nb_at_done = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: inputs change just after posedge, so negedge sees a
  // settled view of the cycle about to be committed.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_write_data);
      end
      if (s_ready && !s_valid && mem_we) gap_we++;
      if (done) begin
        done_cnt++;
        nb_at_done = num_blocks;
      end
    end
  end

  task automatic pulse_start(input logic [15:0] base);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'd0;
  endtask

  // Offer words 1..offered; optionally idle every other cycle and poke a
  // stray start while the message is in progress.
  task automatic run_msg(input logic [15:0] base, input int offered,
                         input bit use_last, input bit gaps, input bit poke);
    int  i;
    int  cyc;
    bit  acc;
    wa.delete(); wd.delete();
    done_cnt = 0; gap_we = 0;
    pulse_start(base);
    i = 0; cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      if (gaps && (cyc % 2 == 1)) begin
        s_valid = 1'b0; s_last = 1'b0;
      end else if (i < offered) begin
        s_valid = 1'b1;
        s_data  = 32'(i + 1);
        s_last  = use_last && (i == offered - 1);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      if (poke && cyc == 4) begin
        start = 1'b1; base_addr = 16'h0999;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 16'd0;
      if (acc) i++;
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string name, input logic [15:0] base, input int n,
                        input int exp_writes, input logic [7:0] exp_nb,
                        input logic [31:0] exp_len);
    int lim;
    logic [31:0] exp_d;
    check({name, ".writes"}, 32'(wa.size()), 32'(exp_writes));
    check({name, ".done_pulses"}, 32'(done_cnt), 32'd1);
    check({name, ".num_blocks"}, 32'(nb_at_done), 32'(exp_nb));
    check({name, ".num_blocks_held"}, 32'(num_blocks), 32'(exp_nb));
    check({name, ".gap_writes"}, 32'(gap_we), 32'd0);
    lim = (wa.size() < exp_writes) ? wa.size() : exp_writes;
    for (int k = 0; k < lim; k++) begin
      if (k < n)                    exp_d = 32'(k + 1);
      else if (k == n)              exp_d = 32'h8000_0000;
      else if (k == exp_writes - 1) exp_d = exp_len;
      else                          exp_d = 32'd0;
      check($sformatf("%s.addr[%0d]", name, k), 32'(wa[k]), 32'(16'(base + 16'(k))));
      check($sformatf("%s.data[%0d]", name, k), wd[k], exp_d);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.s_ready", 32'(s_ready), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", mem_write_data, 32'd0);
    check("rst.num_blocks", 32'(num_blocks), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle.s_ready", 32'(s_ready), 32'd0);

    // 20 words, two blocks
    run_msg(16'h0100, 20, 1'b1, 1'b0, 1'b0);
    verify("m20", 16'h0100, 20, 32, 8'd2, 32'h0000_0280);

    // 13 words: pad and length fit in one block, no zero fill
    run_msg(16'h0100, 13, 1'b1, 1'b0, 1'b0);
    verify("m13", 16'h0100, 13, 16, 8'd1, 32'h0000_01A0);

    // 14 words: length spills into a second block
    run_msg(16'h0100, 14, 1'b1, 1'b0, 1'b0);
    verify("m14", 16'h0100, 14, 32, 8'd2, 32'h0000_01C0);

    // 20 words with a host gap every other cycle and a stray start in LOAD
    run_msg(16'h0100, 20, 1'b1, 1'b1, 1'b1);
    verify("gap20", 16'h0100, 20, 32, 8'd2, 32'h0000_0280);

    // 25 words offered, no s_last: truncated at MAX_WORDS
    run_msg(16'h0100, 25, 1'b0, 1'b0, 1'b0);
    verify("max25", 16'h0100, 20, 32, 8'd2, 32'h0000_0280);

    // Address wrap at the top of the 16-bit space
    run_msg(16'hFFF8, 13, 1'b1, 1'b0, 1'b0);
    verify("wrap13", 16'hFFF8, 13, 16, 8'd1, 32'h0000_01A0);

    // Reset mid-message after word 5, then a clean 13-word message
    pulse_start(16'h0300);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'(i + 1); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_data = 32'd6;
    check("mid.s_ready_pre", 32'(s_ready), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid.mem_we", 32'(mem_we), 32'd0);
    check("mid.s_ready", 32'(s_ready), 32'd0);
    check("mid.mem_addr", 32'(mem_addr), 32'd0);
    s_valid = 1'b0; s_data = 32'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid.idle_ready", 32'(s_ready), 32'd0);
    run_msg(16'h0100, 13, 1'b1, 1'b0, 1'b0);
    verify("post_rst13", 16'h0100, 13, 16, 8'd1, 32'h0000_01A0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sha_msg_writer
`default_nettype wire
